// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared TMDS symbol constants and framer types
package hdmi_pkg;

  typedef enum logic [1:0] {CTRL, PREAMBLE, GUARD, VIDEO} period_t;

  // One pixel slot as carried through the delay line, syncs already active-high.
  typedef struct packed {
    logic       de;
    logic       vsync;
    logic       hsync;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  localparam int         DELAY_STAGES = 10;
  localparam logic [3:0] PREAMBLE_LEN = 4'd10;
  localparam logic [3:0] GUARD_LEN    = 4'd2;

  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_SYM_CH0 = 10'b1011001100;
  localparam logic [9:0] GUARD_SYM_CH1 = 10'b0100110011;
  localparam logic [9:0] GUARD_SYM_CH2 = 10'b1011001100;

  localparam logic [1:0] PREAMBLE_CTRL_CH1 = 2'b01;
  localparam logic [1:0] PREAMBLE_CTRL_CH2 = 2'b00;

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] ctrl);
    logic [9:0] sym;
    unique case (ctrl)
      2'b00:   sym = CTRL_SYM_00;
      2'b01:   sym = CTRL_SYM_01;
      2'b10:   sym = CTRL_SYM_10;
      default: sym = CTRL_SYM_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_chan_enc.sv
// rtl/tmds_chan_enc.sv - one TMDS channel: 8b/10b video, guard band or control symbol
module tmds_chan_enc
  import hdmi_pkg::*;
#(
  parameter logic [9:0] GUARD_SYM = GUARD_SYM_CH0
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       de,
  input  logic [1:0] ctrl,
  input  logic [7:0] din,
  input  logic       guard_sel,
  output logic [9:0] symbol
);

  logic              use_xnor;
  logic [8:0]        q_m;
  logic [3:0]        n1_din;
  logic [3:0]        n1_qm;
  logic signed [4:0] diff;
  logic signed [4:0] disp;
  logic signed [4:0] disp_nxt;
  logic [9:0]        sym_nxt;

  always_comb begin
    n1_din = 4'd0;
    for (int i = 0; i < 8; i++) n1_din = n1_din + {3'd0, din[i]};
    use_xnor = (n1_din > 4'd4) || (n1_din == 4'd4 && !din[0]);

    q_m[0] = din[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ din[i]) : (q_m[i-1] ^ din[i]);
    q_m[8] = ~use_xnor;

    n1_qm = 4'd0;
    for (int i = 0; i < 8; i++) n1_qm = n1_qm + {3'd0, q_m[i]};
    // ones minus zeros of the transition-minimised byte
    diff = $signed({n1_qm, 1'b0} - 5'd8);

    sym_nxt  = ctrl_symbol(ctrl);
    disp_nxt = 5'sd0;
    if (de) begin
      if (disp == 5'sd0 || diff == 5'sd0) begin
        sym_nxt  = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        disp_nxt = q_m[8] ? disp + diff : disp - diff;
      end else if ((disp > 5'sd0 && diff > 5'sd0) || (disp < 5'sd0 && diff < 5'sd0)) begin
        sym_nxt  = {1'b1, q_m[8], ~q_m[7:0]};
        disp_nxt = disp + $signed({3'b000, q_m[8], 1'b0}) - diff;
      end else begin
        sym_nxt  = {1'b0, q_m[8], q_m[7:0]};
        disp_nxt = disp - $signed({3'b000, ~q_m[8], 1'b0}) + diff;
      end
    end else if (guard_sel) begin
      sym_nxt = GUARD_SYM;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      symbol <= CTRL_SYM_00;
      disp   <= 5'sd0;
    end else begin
      symbol <= sym_nxt;
      disp   <= disp_nxt;
    end
  end

endmodule

// File: rtl/hdmi_tmds_framer.sv
// rtl/hdmi_tmds_framer.sv - DVI/HDMI TMDS framer: delay line, period FSM, three channel encoders
module hdmi_tmds_framer
  import hdmi_pkg::*;
#(
  parameter int BITS_PER_COLOR  = 8,
  parameter int HDMI_MODE       = 1,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                      clk_pixel,
  input  logic                      reset,
  input  logic                      de,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic [BITS_PER_COLOR-1:0] r,
  input  logic [BITS_PER_COLOR-1:0] g,
  input  logic [BITS_PER_COLOR-1:0] b,
  output logic [9:0]                tmds_ch0,
  output logic [9:0]                tmds_ch1,
  output logic [9:0]                tmds_ch2,
  output logic                      video_period
);

  function automatic logic [7:0] widen(input logic [BITS_PER_COLOR-1:0] c);
    return 8'({c, c} >> (2 * BITS_PER_COLOR - 8));
  endfunction

  logic    hs_n, vs_n;
  pix_t    pix_in;
  pix_t    dly [DELAY_STAGES];
  pix_t    st_pix;
  period_t state, state_nxt;
  logic [3:0] cnt, cnt_eff, cnt_nxt;
  logic    de_rise;

  assign hs_n   = (SYNC_ACTIVE_LOW != 0) ? ~hsync : hsync;
  assign vs_n   = (SYNC_ACTIVE_LOW != 0) ? ~vsync : vsync;
  assign pix_in = {de, vs_n, hs_n, widen(r), widen(g), widen(b)};

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DELAY_STAGES; i++) dly[i] <= '0;
    end else begin
      dly[0] <= pix_in;
      for (int i = 1; i < DELAY_STAGES; i++) dly[i] <= dly[i-1];
    end
  end

  // The rise is seen at the line input, so the countdown runs ahead of the
  // delayed slots and ends exactly as the first pixel leaves the line.
  assign de_rise = de & ~dly[0].de;

  always_comb begin
    cnt_eff   = de_rise ? PREAMBLE_LEN : cnt;
    cnt_nxt   = (cnt_eff != 4'd0) ? cnt_eff - 4'd1 : 4'd0;
    state_nxt = CTRL;
    if (dly[DELAY_STAGES-1].de)
      state_nxt = VIDEO;
    else if (HDMI_MODE != 0 && cnt_eff > GUARD_LEN)
      state_nxt = PREAMBLE;
    else if (HDMI_MODE != 0 && cnt_eff != 4'd0)
      state_nxt = GUARD;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state  <= CTRL;
      cnt    <= 4'd0;
      st_pix <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      st_pix <= dly[DELAY_STAGES-1];
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) video_period <= 1'b0;
    else       video_period <= (state == VIDEO);
  end

  tmds_chan_enc #(.GUARD_SYM(GUARD_SYM_CH0)) u_enc_ch0 (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .de        (state == VIDEO),
    .ctrl      ({st_pix.vsync, st_pix.hsync}),
    .din       (st_pix.b),
    .guard_sel (state == GUARD),
    .symbol    (tmds_ch0)
  );

  tmds_chan_enc #(.GUARD_SYM(GUARD_SYM_CH1)) u_enc_ch1 (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .de        (state == VIDEO),
    .ctrl      ((state == PREAMBLE) ? PREAMBLE_CTRL_CH1 : 2'b00),
    .din       (st_pix.g),
    .guard_sel (state == GUARD),
    .symbol    (tmds_ch1)
  );

  tmds_chan_enc #(.GUARD_SYM(GUARD_SYM_CH2)) u_enc_ch2 (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .de        (state == VIDEO),
    .ctrl      ((state == PREAMBLE) ? PREAMBLE_CTRL_CH2 : 2'b00),
    .din       (st_pix.r),
    .guard_sel (state == GUARD),
    .symbol    (tmds_ch2)
  );

endmodule
